// File: rtl/gemm_da_stream.sv
// Bit-serial distributed-arithmetic GEMM, one A bit-plane per cycle, streaming rows.
// Define GEMM_DA_RELU_EN to fuse a ReLU after output saturation.
module gemm_da_stream #(
  parameter int AW     = 8,
  parameter int BW     = 8,
  parameter int BIAS_W = 16,
  parameter int OUT_W  = 8,
  parameter int M      = 2,
  parameter int N      = 4,
  parameter int K      = 16,
  parameter int SH_W   = 5,
  parameter int ACC_W  = AW + BW + $clog2(K) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [M*K*AW-1:0]     a_flat,
  input  logic [K*N*BW-1:0]     b_flat,
  input  logic [N*BIAS_W-1:0]   bias_flat,
  input  logic                  bias_en,
  input  logic [SH_W-1:0]       shamt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*OUT_W-1:0]    out_row,
  output logic                  out_last,
  output logic                  busy
);

  localparam int MW = (M > 1) ? $clog2(M) : 1;
  localparam int TW = $clog2(AW);
  // wide enough that the rounding constant never truncates for any shift
  localparam int RW = ACC_W + (1 << SH_W) + 1;
  localparam logic signed [RW-1:0] MAXV = (RW'(1) <<< (OUT_W - 1)) - RW'(1);
  localparam logic signed [RW-1:0] MINV = -(MAXV + RW'(1));

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  state_t                   state;
  logic [M*K*AW-1:0]        a_q;
  logic [K*N*BW-1:0]        b_q;
  logic [N*BIAS_W-1:0]      bias_q;
  logic [SH_W-1:0]          sh_q;
  logic [MW-1:0]            m;
  logic [TW-1:0]            t;
  logic signed [ACC_W-1:0]  acc    [N];
  logic signed [ACC_W-1:0]  acc_nx [N];
  logic signed [ACC_W-1:0]  psum   [N];
  logic signed [ACC_W-1:0]  term   [N];
  logic signed [RW-1:0]     v      [N];
  logic signed [RW-1:0]     r      [N];
  logic signed [RW-1:0]     rnd;
  logic [N*OUT_W-1:0]       row_nx;
  logic [OUT_W-1:0]         lane;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_comb begin
    rnd = '0;
    if (sh_q != '0) rnd[sh_q - 1'b1] = 1'b1;
    row_nx = '0;
    lane   = '0;
    for (int n = 0; n < N; n++) begin
      psum[n] = '0;
      for (int k = 0; k < K; k++) begin
        if (a_q[(int'(m) * K + k) * AW + int'(t)])
          psum[n] = psum[n] + ACC_W'($signed(b_q[(k * N + n) * BW +: BW]));
      end
      // MSB plane of A carries negative weight
      term[n]   = (t == TW'(AW - 1)) ? -psum[n] : psum[n];
      acc_nx[n] = ((t == '0) ? ACC_W'(0) : acc[n]) + (term[n] <<< t);
      v[n] = RW'(acc_nx[n]) + RW'($signed(bias_q[n * BIAS_W +: BIAS_W]));
      r[n] = (sh_q == '0) ? v[n] : ((v[n] + rnd) >>> sh_q);
      lane = r[n][OUT_W-1:0];
      if (r[n] > MAXV)
        lane = {1'b0, {(OUT_W - 1){1'b1}}};
      else if (r[n] < MINV)
        lane = {1'b1, {(OUT_W - 1){1'b0}}};
`ifdef GEMM_DA_RELU_EN
      if (r[n] < 0) lane = '0;
`else
`endif
      row_nx[n * OUT_W +: OUT_W] = lane;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      bias_q    <= '0;
      sh_q      <= '0;
      m         <= '0;
      t         <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_last  <= 1'b0;
      for (int n = 0; n < N; n++) acc[n] <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          a_q    <= a_flat;
          b_q    <= b_flat;
          bias_q <= bias_en ? bias_flat : '0;
          sh_q   <= shamt;
          m      <= '0;
          t      <= '0;
          state  <= RUN;
        end
        RUN: begin
          for (int n = 0; n < N; n++) acc[n] <= acc_nx[n];
          if (t == TW'(AW - 1)) begin
            out_row   <= row_nx;
            out_valid <= 1'b1;
            out_last  <= (m == MW'(M - 1));
            state     <= OUT;
          end else begin
            t <= t + 1'b1;
          end
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          if (m == MW'(M - 1)) begin
            state <= IDLE;
          end else begin
            m     <= m + 1'b1;
            t     <= '0;
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gemm_da_stream.md
Name: gemm_da_stream

Overview:
- Parametrised successor to the team's bit-serial distributed-arithmetic (DA) GEMM.
- Computes C = A·B + bias for an M×K kernel matrix A and a K×N feature-map tile B.
- Processes one A bit-plane per cycle and emits one requantised N-wide output row per handshake.
- Sits between the im2col/tile buffer (input side) and the activation writeback FIFO (output side). Valid/ready on both sides replaces the free-running gen_done sequencing.

Parameters:
- AW, 8, kernel (A) element width, signed two's complement, ≥2
- BW, 8, feature-map (B) element width, signed
- BIAS_W, 16, bias element width, signed
- OUT_W, 8, output element width, signed
- M, 2, output rows per job (A rows)
- N, 4, output columns (B columns, parallel DA lanes)
- K, 16, reduction depth, ≥2
- SH_W, 5, width of the requantisation shift amount
- ACC_W, AW+BW+$clog2(K)+1, accumulator width; must be ≥ BIAS_W+1

Ports:
- clk, in, 1, clock
- rst, in, 1, reset, asynchronous, active-high
- in_valid, in, 1, job operands valid
- in_ready, out, 1, block idle, job accepted when in_valid && in_ready
- a_flat, in, M*K*AW, A[m][k] at bits ((m*K+k)*AW) +: AW
- b_flat, in, K*N*BW, B[k][n] at bits ((k*N+n)*BW) +: BW
- bias_flat, in, N*BIAS_W, bias[n] at bits (n*BIAS_W) +: BIAS_W
- bias_en, in, 1, add bias when 1; sampled at accept
- shamt, in, SH_W, arithmetic right-shift for requantisation; sampled at accept
- out_valid, out, 1, out_row valid
- out_ready, in, 1, downstream accepts row
- out_row, out, N*OUT_W, C[m][n] at bits (n*OUT_W) +: OUT_W
- out_last, out, 1, high with the row m = M-1
- busy, out, 1, state != IDLE

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - State = IDLE, all counters = 0, accumulators = 0.
  - out_valid = 0, out_row = 0, out_last = 0, busy = 0; in_ready = 1 after reset release.
  - Reset mid-job aborts the job without emitting any partial row.
- Accept: on the edge where in_valid && in_ready, register a_flat, b_flat, bias (zeroed if !bias_en) and shamt. Set m = 0, t = 0, state = RUN.
- in_ready = (state == IDLE). Input is never accepted while busy.
- RUN, one cycle per bit t = 0..AW-1 of row m:
  - psum[n] = Σ_k A[m][k][t] · B[k][n], sign-extended to ACC_W. This is the DA LUT lookup; it may be implemented as an adder tree.
  - acc[n] <= (t==0 ? 0 : acc[n]) + ((t==AW-1 ? -psum[n] : psum[n]) <<< t). The sign bit carries negative weight.
  - At t = AW-1, go to OUT and register out_row from the final value.
- Requantisation per lane:
  - v = acc + sign-extended bias.
  - If shamt > 0: r = (v + 2^(shamt-1)) >>> shamt (round-half-up). If shamt = 0: r = v.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Latency: out_valid rises exactly AW edges after the accepting edge for row 0. Each later row appears AW edges after the previous row's out handshake.
- OUT: out_valid = 1, out_last = (m == M-1).
  - out_row and out_last stay stable while out_valid && !out_ready.
  - On out_ready with m < M-1: m++, t = 0, go to RUN.
  - On out_ready with m == M-1: go to IDLE. in_ready = 1 on the next cycle; there is no back-to-back overlap.
- Throughput: M·(AW+1) cycles per job with out_ready tied high.
- Arithmetic: the accumulator never overflows by construction of ACC_W. Saturation is applied only at output.

Optional Feature:
- Macro GEMM_DA_RELU_EN.
- Defined: after saturation, negative lanes are forced to 0 (fused ReLU). Output range is [0, 2^(OUT_W-1)-1].
- Undefined: signed saturated result is output unchanged. No ReLU logic is present.

Test Plan:
- All bench cases use M=2, N=2, K=4, AW=BW=8, OUT_W=8.
- Identity sum: all A=1, all B=1, bias_en=0, shamt=0, out_ready=1.
  - Required: out_row = {4,4} for both rows.
  - Required: first out_valid 8 edges after accept, second 9 edges after the first; out_last only on row 1.
- Positive saturate: all A=-128, all B=-128, shamt=8 → 65536>>8 = 256 → out = 127 per lane.
- Negative saturate: all A=-128, all B=127, shamt=8 → -254 → out = -128; with GEMM_DA_RELU_EN → 0.
- Rounding plus bias:
  - Row0 A = [3,0,0,0], B[0][*] = 1, shamt=1, bias_en=0 → out 2.
  - Same with A[0][0] = -3 → out -1.
  - bias_en=1, bias = {10,-10}, shamt=0 → {13,-7}.
- Backpressure: hold out_ready=0 for 5 cycles on row 0.
  - Required: out_row stable, no row-1 computation, in_ready=0.
  - Required: after release, row 1 arrives 8 edges later.
- Reset mid-job: assert rst at t=3 of row 1.
  - Required: out_valid=0 and busy=0 immediately, in_ready=1 after release.
  - Required: a new job then produces correct results.
